instr_fetch_unit: RTL and testbench

//  Fetch stage. Owns the fetch PC and issues one-at-a-time req/ack reads to instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types: state encoding, queue entry layout and instruction constants.
package instr_fetch_unit_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic            fault;
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched entries; flush empties it, empty head reads as all zeros.
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wr_entry,
  output fetch_entry_t               head,
  output logic                       empty,
  output logic [$clog2(QDEPTH):0]    count
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  fetch_entry_t mem [QDEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign head  = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single outstanding imem reads and queues results for decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QFULL = (CW + 1)'(QDEPTH);

  fetch_state_t   state, state_n;
  logic [31:0]    fetch_pc;
  logic [31:0]    drain_addr;
  logic [31:0]    fault_pc;
  logic           pend_fault;
  logic           misaligned;
  logic           q_push, q_pop, q_empty;
  logic [CW-1:0]  q_count;
  logic [CW:0]    count_next;
  fetch_entry_t   q_wr, q_head;

  assign misaligned = |redirect_pc[1:0];
  assign q_pop      = !q_empty && dec_ready && !redirect;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (q_push),
    .pop      (q_pop),
    .wr_entry (q_wr),
    .head     (q_head),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign if_valid = !q_empty;
  assign if_instr = q_head.instr;
  assign if_pc    = q_head.pc;
  assign if_fault = q_head.fault;

  // The fault marker is pushed on the first S_FAULT cycle, so it also covers the post-drain case.
  always_comb begin
    q_push = 1'b0;
    q_wr   = '{fault: 1'b0, pc: fetch_pc, instr: imem_rdata};
    if (state == S_REQ && imem_ack) begin
      q_push = 1'b1;
    end else if (state == S_FAULT && pend_fault) begin
      q_push = 1'b1;
      q_wr   = '{fault: 1'b1, pc: fault_pc, instr: NOP_INSTR};
    end
    if (redirect) q_push = 1'b0;
    count_next = {1'b0, q_count} + (CW + 1)'(q_push) - (CW + 1)'(q_pop);
  end

  always_comb begin
    state_n   = state;
    imem_req  = (state == S_REQ) || (state == S_DRAIN);
    imem_addr = (state == S_DRAIN) ? drain_addr : fetch_pc;
    unique case (state)
      S_IDLE:  if (count_next < QFULL) state_n = S_REQ;
      S_REQ:   if (imem_ack) state_n = (count_next < QFULL) ? S_REQ : S_IDLE;
      S_DRAIN: if (imem_ack) state_n = pend_fault ? S_FAULT : S_REQ;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase
    if (redirect) begin
      if (imem_req && !imem_ack) state_n = S_DRAIN;
      else                       state_n = misaligned ? S_FAULT : S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      fault_pc   <= RESET_PC;
      pend_fault <= 1'b0;
    end else begin
      state <= state_n;
      if (redirect) begin
        fetch_pc   <= {redirect_pc[31:2], 2'b00};
        fault_pc   <= redirect_pc;
        pend_fault <= misaligned;
        // Only a fresh abandon captures the address; a redirect mid-drain keeps the old one.
        if (state == S_REQ && !imem_ack) drain_addr <= fetch_pc;
      end else begin
        if (state == S_REQ && imem_ack) fetch_pc <= fetch_pc + 32'd4;
        if (state == S_FAULT && pend_fault) pend_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic against a stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int unsigned QD     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: next expected request address, next expected decoded pc, pending drain, fault marker.
  logic [31:0] req_pc, exp_pc, marker_pc, prev_addr;
  bit          stale, marker_mode, marker_done;
  bit          prev_redir, prev_pend, hs, pop;

  instr_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_fault    (if_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    req_pc      = RST_PC;
    exp_pc      = RST_PC;
    marker_pc   = '0;
    stale       = 0;
    marker_mode = 0;
    marker_done = 0;
  endtask

  // One clock: check outputs at this negedge, drive inputs, advance the model, wait for next negedge.
  task automatic step(input logic r, input logic a, input logic rd, input logic [31:0] rpc,
                      input logic rdy);
    if (prev_redir) chk("flush", 32'(if_valid), 32'd0);
    if (prev_pend) begin
      chk("addr_hold", imem_addr, prev_addr);
      chk("req_hold", 32'(imem_req), 32'd1);
    end
    if (!if_valid) chk("empty_zero", if_instr | if_pc | 32'(if_fault), 32'd0);
    if (marker_mode && !stale) chk("fault_noreq", 32'(imem_req), 32'd0);

    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    dec_ready   = rdy;
    imem_ack    = a & imem_req;
    hs          = imem_req && imem_ack && !r;
    pop         = if_valid && rdy && !rd && !r;

    if (r) begin
      model_reset();
    end else begin
      if (pop) begin
        if (!marker_mode) begin
          chk("pop_pc", if_pc, exp_pc);
          chk("pop_instr", if_instr, mem_word(exp_pc));
          chk("pop_fault", 32'(if_fault), 32'd0);
          exp_pc += 32'd4;
        end else if (!marker_done) begin
          chk("mark_pc", if_pc, marker_pc);
          chk("mark_instr", if_instr, 32'h0000_0013);
          chk("mark_fault", 32'(if_fault), 32'd1);
          marker_done = 1;
        end else begin
          chk("extra_entry", 32'(if_valid), 32'd0);
        end
      end
      if (hs) begin
        if (!rd && !stale) begin
          chk("req_addr", imem_addr, req_pc);
          req_pc += 32'd4;
        end
        stale = 0;
      end
      if (rd) begin
        if (imem_req && !imem_ack) stale = 1;
        req_pc      = {rpc[31:2], 2'b00};
        exp_pc      = {rpc[31:2], 2'b00};
        marker_mode = |rpc[1:0];
        marker_pc   = rpc;
        marker_done = 0;
      end
    end
    prev_redir = rd && !r;
    prev_pend  = imem_req && !imem_ack && !r;
    prev_addr  = imem_addr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_hs;
    int unsigned n_pop;
    bit          saw_marker;
    logic [31:0] v;

    rst = 1'b1; imem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    prev_redir = 0; prev_pend = 0; prev_addr = '0;
    model_reset();
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_fault", 32'(if_fault), 32'd0);

    // Streaming across the 32-bit wrap
    step(0, 1, 0, 0, 1);
    n_pop = 0;
    for (int i = 0; i < 24; i++) begin
      chk("stream_req", 32'(imem_req), 32'd1);
      step(0, 1, 0, 0, 1);
      if (pop) n_pop++;
    end
    chk("stream_pops", 32'(n_pop >= 20), 32'd1);

    // Backpressure
    step(0, 1, 1, 32'h40, 1);
    n_hs = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 0);
      if (hs) n_hs++;
    end
    chk("bp_pushes", n_hs, 32'(QD));
    chk("bp_idle", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(if_valid), 32'd1);
    step(0, 1, 0, 0, 1);
    chk("bp_resume", 32'(imem_req), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);

    // Redirect while a request is outstanding
    step(0, 1, 1, 32'h10, 1);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr0", imem_addr, 32'h10);
    step(0, 0, 1, 32'h200, 1);
    for (int i = 0; i < 2; i++) begin
      chk("t3_drain_addr", imem_addr, 32'h10);
      step(0, 0, 0, 0, 1);
    end
    chk("t3_drain_addr", imem_addr, 32'h10);
    step(0, 1, 0, 0, 1);
    chk("t3_newaddr", imem_addr, 32'h200);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);

    // Redirect with same-cycle ack and pop
    chk("t4_pre_valid", 32'(if_valid), 32'd1);
    chk("t4_pre_req", 32'(imem_req), 32'd1);
    step(0, 1, 1, 32'h480, 1);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h480);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);

    // Misaligned redirect
    step(0, 1, 1, 32'h102, 1);
    saw_marker = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_valid && if_fault) saw_marker = 1;
      step(0, 1'($urandom_range(0, 1)), 0, 0, 1);
    end
    chk("t5_marker_seen", 32'(saw_marker), 32'd1);
    chk("t5_noreq", 32'(imem_req), 32'd0);
    step(0, 1, 1, 32'h300, 1);
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h300);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, v,
           $urandom_range(0, 3) != 0);
    end

    // Reset in the middle of a drain
    step(0, 1, 1, 32'h600, 1);
    step(0, 0, 1, 32'h700, 1);
    step(0, 0, 0, 0, 1);
    chk("r2_draining", imem_addr, 32'h600);
    step(1, 0, 0, 0, 1);
    chk("r2_req", 32'(imem_req), 32'd0);
    chk("r2_addr", imem_addr, RST_PC);
    chk("r2_valid", 32'(if_valid), 32'd0);
    chk("r2_zero", if_instr | if_pc | 32'(if_fault), 32'd0);
    step(0, 1, 0, 0, 1);
    chk("r2_restart_addr", imem_addr, RST_PC);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
